// File: rtl/branch_cmp_seq.sv
// Registered MIPS branch-condition unit: one-cycle zero/sign/equality tests plus a multi-cycle
// popcount-equality compare (bnumeq), built only when BRANCH_CMP_POPCNT_EN is defined.
module branch_cmp_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic             taken,
  output logic             illegal
);

  localparam logic [3:0] OP_BEQ  = 4'd0;
  localparam logic [3:0] OP_BNE  = 4'd1;
  localparam logic [3:0] OP_BLEZ = 4'd2;
  localparam logic [3:0] OP_BGTZ = 4'd3;
  localparam logic [3:0] OP_BLTZ = 4'd4;
  localparam logic [3:0] OP_BGEZ = 4'd5;
  localparam logic signed [WIDTH-1:0] ZERO_S = '0;

  if (WIDTH < 2) begin : g_chk_width
    $error("branch_cmp_seq: WIDTH must be >= 2");
  end
  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_chk_chunk
    $error("branch_cmp_seq: CHUNK must be in 1..WIDTH");
  end

  function automatic logic simple_cond(input logic [3:0]       f_op,
                                       input logic [WIDTH-1:0] f_a,
                                       input logic [WIDTH-1:0] f_b);
    logic signed [WIDTH-1:0] v_a;
    v_a = $signed(f_a);
    case (f_op)
      OP_BEQ:  simple_cond = (f_a == f_b);
      OP_BNE:  simple_cond = (f_a != f_b);
      OP_BLEZ: simple_cond = (v_a <= ZERO_S);
      OP_BGTZ: simple_cond = (v_a > ZERO_S);
      OP_BLTZ: simple_cond = f_a[WIDTH-1];
      OP_BGEZ: simple_cond = ~f_a[WIDTH-1];
      default: simple_cond = 1'b0;
    endcase
  endfunction

  logic w_idle;
  logic w_op_pop;
  logic w_op_ill;
  logic w_pop_done;
  logic w_pop_taken;
  logic r_valid;
  logic r_taken;
  logic r_illegal;

`ifdef BRANCH_CMP_POPCNT_EN
  localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0] OP_BNUMEQ = 4'd6;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  function automatic logic [CW-1:0] popcnt(input logic [CHUNK-1:0] f_v);
    logic [CW-1:0] v_n;
    v_n = '0;
    for (int i = 0; i < CHUNK; i++) begin
      v_n = v_n + CW'(f_v[i]);
    end
    return v_n;
  endfunction

  logic [0:0]       r_state;
  logic [KW-1:0]    r_k;
  logic [CW-1:0]    r_cnt_a;
  logic [CW-1:0]    r_cnt_b;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    w_sum_a;
  logic [CW-1:0]    w_sum_b;
  logic             w_last;
  logic             w_accept_pop;

  assign w_idle       = (r_state == S_IDLE);
  assign w_op_pop     = (op == OP_BNUMEQ);
  assign w_accept_pop = w_idle && start && w_op_pop;
  // Operands shift right each COUNT cycle, so the current chunk always sits in the low bits
  // and the zero fill naturally blanks bits past WIDTH in a partial last chunk.
  assign w_sum_a      = r_cnt_a + popcnt(r_a[CHUNK-1:0]);
  assign w_sum_b      = r_cnt_b + popcnt(r_b[CHUNK-1:0]);
  assign w_last       = (r_k == KW'(N - 1));
  assign w_pop_done   = (r_state == S_COUNT) && w_last;
  assign w_pop_taken  = (w_sum_a == w_sum_b);
  assign busy         = (r_state == S_COUNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else if (w_idle) begin
      if (w_accept_pop) begin
        r_state <= S_COUNT;
        r_k     <= '0;
        r_cnt_a <= '0;
        r_cnt_b <= '0;
      end
    end else begin
      r_cnt_a <= w_sum_a;
      r_cnt_b <= w_sum_b;
      if (w_last) begin
        r_state <= S_IDLE;
        r_k     <= '0;
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept_pop && !flush) begin
      r_a <= a;
      r_b <= b;
    end else if (r_state == S_COUNT) begin
      r_a <= r_a >> CHUNK;
      r_b <= r_b >> CHUNK;
    end
  end
`else
  assign w_idle      = 1'b1;
  assign w_op_pop    = 1'b0;
  assign w_pop_done  = 1'b0;
  assign w_pop_taken = 1'b0;
  assign busy        = 1'b0;
`endif

  assign w_op_ill = (op > OP_BGEZ) && !w_op_pop;

  // Result register: flush wipes the held result, otherwise valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_pop_done) begin
        r_valid   <= 1'b1;
        r_taken   <= w_pop_taken;
        r_illegal <= 1'b0;
      end else if (w_idle && start && !w_op_pop) begin
        r_valid   <= 1'b1;
        r_taken   <= w_op_ill ? 1'b0 : simple_cond(op, a, b);
        r_illegal <= w_op_ill;
      end
    end
  end

  assign valid   = r_valid;
  assign taken   = r_taken;
  assign illegal = r_illegal;

endmodule
